// File: rtl/l1_l2_arbiter_pkg.sv
// rtl/l1_l2_arbiter_pkg.sv - shared types and grant decision for the L1-to-L2 arbiter
package l1_l2_arbiter_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IC   = 2'd1,
        ARB_DC   = 2'd2
    } arb_owner_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IC = 2'd1,
        ST_GRANT_DC = 2'd2
    } arb_state_e;

    // Ties go to dc, or to whichever port was not served last when round robin is on.
    function automatic arb_state_e l1_l2_arb_pick(
        input logic ic_valid,
        input logic dc_valid,
        input logic last_grant_dc,
        input logic round_robin
    );
        arb_state_e pick;
        pick = ST_IDLE;
        if (ic_valid && dc_valid) begin
            if (round_robin && last_grant_dc) begin
                pick = ST_GRANT_IC;
            end else begin
                pick = ST_GRANT_DC;
            end
        end else if (dc_valid) begin
            pick = ST_GRANT_DC;
        end else if (ic_valid) begin
            pick = ST_GRANT_IC;
        end
        return pick;
    endfunction

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// rtl/l1_l2_arbiter_if.sv - memory request/fulfil handshake between an L1 and L2
interface l1_l2_arbiter_if
    import l1_l2_arbiter_pkg::*;
#(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   req_address;
    memory_operation_e req_type;
    logic              req_valid;
    logic [XLEN-1:0]   word_to_store;
    logic [XLEN-1:0]   fetched_word;
    logic              req_fulfilled;

    modport master (
        output req_address,
        output req_type,
        output req_valid,
        output word_to_store,
        input  fetched_word,
        input  req_fulfilled
    );

    modport slave (
        input  req_address,
        input  req_type,
        input  req_valid,
        input  word_to_store,
        output fetched_word,
        output req_fulfilled
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - shares one L2 port between icache and dcache; ARB_ROUND_ROBIN_EN selects round-robin ties
module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LINE_SIZE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    l1_l2_arbiter_if.slave   ic,
    l1_l2_arbiter_if.slave   dc,
    l1_l2_arbiter_if.master  l2,
    output arb_owner_e       arb_owner,
    output logic             beat_overrun
);

    localparam int BEATS = LINE_SIZE / 4;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic ROUND_ROBIN = 1'b1;
`else
    localparam logic ROUND_ROBIN = 1'b0;
`endif

    arb_state_e    state;
    logic          last_grant_dc;
    logic [CW-1:0] beat_count;

    // Pure muxing from the registered state keeps a granted L1 at zero added latency.
    always_comb begin
        l2.req_address   = {XLEN{1'b0}};
        l2.req_type      = LOAD;
        l2.req_valid     = 1'b0;
        l2.word_to_store = {XLEN{1'b0}};
        ic.req_fulfilled = 1'b0;
        dc.req_fulfilled = 1'b0;
        ic.fetched_word  = l2.fetched_word;
        dc.fetched_word  = l2.fetched_word;
        arb_owner        = ARB_IDLE;
        case (state)
            ST_GRANT_IC: begin
                l2.req_address   = ic.req_address;
                l2.req_type      = ic.req_type;
                l2.req_valid     = ic.req_valid;
                l2.word_to_store = ic.word_to_store;
                ic.req_fulfilled = l2.req_fulfilled;
                arb_owner        = ARB_IC;
            end
            ST_GRANT_DC: begin
                l2.req_address   = dc.req_address;
                l2.req_type      = dc.req_type;
                l2.req_valid     = dc.req_valid;
                l2.word_to_store = dc.word_to_store;
                dc.req_fulfilled = l2.req_fulfilled;
                arb_owner        = ARB_DC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            last_grant_dc <= 1'b0;
            beat_count    <= '0;
            beat_overrun  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= l1_l2_arb_pick(ic.req_valid, dc.req_valid, last_grant_dc, ROUND_ROBIN);
                end
                ST_GRANT_IC: begin
                    if (!ic.req_valid) begin
                        last_grant_dc <= 1'b0;
                        beat_count    <= '0;
                        state         <= l1_l2_arb_pick(1'b0, dc.req_valid, 1'b0, ROUND_ROBIN);
                    end else if (l2.req_fulfilled) begin
                        if (beat_count == BEATS_C) begin
                            beat_overrun <= 1'b1;
                        end else begin
                            beat_count <= beat_count + 1'b1;
                        end
                    end
                end
                ST_GRANT_DC: begin
                    if (!dc.req_valid) begin
                        last_grant_dc <= 1'b1;
                        beat_count    <= '0;
                        state         <= l1_l2_arb_pick(ic.req_valid, 1'b0, 1'b1, ROUND_ROBIN);
                    end else if (l2.req_fulfilled) begin
                        if (beat_count == BEATS_C) begin
                            beat_overrun <= 1'b1;
                        end else begin
                            beat_count <= beat_count + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb/tb_l1_l2_arbiter.sv - scoreboard bench for l1_l2_arbiter with a behavioural grant model
module tb_l1_l2_arbiter;
    import l1_l2_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       l2_fire = 1'b0;
    arb_owner_e arb_owner;
    logic       beat_overrun;

    always #5 clk = ~clk;

    l1_l2_arbiter_if #(.XLEN(32)) ic_if ();
    l1_l2_arbiter_if #(.XLEN(32)) dc_if ();
    l1_l2_arbiter_if #(.XLEN(32)) l2_if ();

    l1_l2_arbiter #(.XLEN(32), .LINE_SIZE(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ic           (ic_if),
        .dc           (dc_if),
        .l2           (l2_if),
        .arb_owner    (arb_owner),
        .beat_overrun (beat_overrun)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h0101};
    endfunction

    // L2 memory model: combinational fulfil, word derived from address.
    assign l2_if.req_fulfilled = l2_fire & l2_if.req_valid;
    assign l2_if.fetched_word  = mem_word(l2_if.req_address);

    typedef struct {
        int          owner;
        bit          l2v;
        logic [31:0] addr;
        bit          st;
        logic [31:0] wts;
        bit          icf;
        bit          dcf;
        logic [31:0] word;
        bit          ovr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   fails = 0;

`ifdef ARB_ROUND_ROBIN_EN
    bit rr = 1'b1;
`else
    bit rr = 1'b0;
`endif

    // Behavioural model: 0 = nobody, 1 = icache, 2 = dcache.
    int m_owner = 0;
    int m_last  = 1;
    int m_beats = 0;
    bit m_ovr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_beats = 0;
        m_ovr   = 1'b0;
    endtask

    task automatic cycle(input bit icv, input bit dcv, input logic [31:0] ica, input logic [31:0] dca,
                         input bit ict, input bit dct, input bit fire);
        exp_t e;
        bit mine, other;
        @(negedge clk);
        ic_if.req_valid     = icv;
        ic_if.req_address   = ica;
        ic_if.req_type      = ict ? STORE : LOAD;
        ic_if.word_to_store = ~ica;
        dc_if.req_valid     = dcv;
        dc_if.req_address   = dca;
        dc_if.req_type      = dct ? STORE : LOAD;
        dc_if.word_to_store = ~dca;
        l2_fire             = fire;
        #1;
        e.owner = m_owner;
        e.l2v   = (m_owner == 1) ? icv : (m_owner == 2) ? dcv : 1'b0;
        e.addr  = (m_owner == 1) ? ica : dca;
        e.st    = (m_owner == 1) ? ict : dct;
        e.wts   = ~e.addr;
        e.icf   = (m_owner == 1) && icv && fire;
        e.dcf   = (m_owner == 2) && dcv && fire;
        e.word  = mem_word(e.addr);
        e.ovr   = m_ovr;
        sb.push_back(e);
        if (m_owner == 0) begin
            if (icv && dcv) m_owner = (rr && m_last == 2) ? 1 : 2;
            else if (dcv)   m_owner = 2;
            else if (icv)   m_owner = 1;
        end else begin
            mine  = (m_owner == 1) ? icv : dcv;
            other = (m_owner == 1) ? dcv : icv;
            if (!mine) begin
                m_last  = m_owner;
                m_beats = 0;
                m_owner = other ? 3 - m_owner : 0;
            end else if (fire) begin
                if (m_beats >= 4) m_ovr = 1'b1;
                else m_beats++;
            end
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("arb_owner", 32'(arb_owner),
                (mon_e.owner == 1) ? 32'(ARB_IC) : (mon_e.owner == 2) ? 32'(ARB_DC) : 32'(ARB_IDLE));
            chk("l2_req_valid", 32'(l2_if.req_valid), 32'(mon_e.l2v));
            chk("ic_req_fulfilled", 32'(ic_if.req_fulfilled), 32'(mon_e.icf));
            chk("dc_req_fulfilled", 32'(dc_if.req_fulfilled), 32'(mon_e.dcf));
            chk("beat_overrun", 32'(beat_overrun), 32'(mon_e.ovr));
            if (mon_e.owner != 0) begin
                chk("l2_req_address", l2_if.req_address, mon_e.addr);
                chk("l2_req_type", 32'(l2_if.req_type), 32'(mon_e.st));
                chk("l2_word_to_store", l2_if.word_to_store, mon_e.wts);
            end
            if (mon_e.icf) chk("ic_fetched_word", ic_if.fetched_word, mon_e.word);
            if (mon_e.dcf) chk("dc_fetched_word", dc_if.fetched_word, mon_e.word);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit icv, dcv;
        ic_if.req_valid = 1'b0; ic_if.req_address = '0; ic_if.req_type = LOAD; ic_if.word_to_store = '0;
        dc_if.req_valid = 1'b0; dc_if.req_address = '0; dc_if.req_type = LOAD; dc_if.word_to_store = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_owner", 32'(arb_owner), 32'(ARB_IDLE));
        chk("reset_l2_valid", 32'(l2_if.req_valid), 32'd0);
        chk("reset_overrun", 32'(beat_overrun), 32'd0);
        chk("reset_ic_ful", 32'(ic_if.req_fulfilled), 32'd0);
        chk("reset_dc_ful", 32'(dc_if.req_fulfilled), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // simultaneous request from reset, then dc drops and ic takes over without a bubble
        cycle(1, 1, 32'h0000_0100, 32'h0000_0200, 0, 0, 0);
        cycle(1, 1, 32'h0000_0100, 32'h0000_0200, 0, 0, 1);
        cycle(1, 1, 32'h0000_0104, 32'h0000_0204, 0, 0, 1);
        cycle(1, 0, 32'h0000_0100, 32'h0000_0200, 0, 0, 1);
        cycle(1, 0, 32'h0000_0104, 32'h0000_0200, 0, 0, 1);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(1, 1, 32'h0000_0500, 32'h0000_0600, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // dcache-only four-beat load
        for (int i = 0; i < 5; i++)
            cycle(0, 1, 32'h0, 32'h0000_1000 + 32'(i * 4), 0, 0, i != 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // ic mid-fill while dc asks; ic keeps the grant through beat 4
        cycle(1, 0, 32'h0000_0800, 32'h0, 0, 0, 0);
        cycle(1, 0, 32'h0000_0800, 32'h0, 0, 0, 1);
        cycle(1, 0, 32'h0000_0804, 32'h0, 0, 0, 1);
        cycle(1, 1, 32'h0000_0808, 32'h0000_0900, 0, 0, 1);
        cycle(1, 1, 32'h0000_080C, 32'h0000_0900, 0, 0, 1);
        cycle(0, 1, 32'h0, 32'h0000_0900, 0, 0, 1);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // writeback then refill in one dcache tenure
        cycle(0, 1, 32'h0, 32'h0000_2040, 0, 1, 0);
        cycle(0, 1, 32'h0, 32'h0000_2040, 0, 1, 1);
        cycle(0, 1, 32'h0, 32'h0000_2044, 0, 1, 1);
        cycle(0, 1, 32'h0, 32'h0000_3040, 0, 0, 1);
        cycle(0, 1, 32'h0, 32'h0000_3044, 0, 0, 1);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // five beats in one tenure trip the sticky overrun flag
        for (int i = 0; i < 8; i++)
            cycle(0, 1, 32'h0, 32'h0000_7000 + 32'(i * 4), 0, 0, i != 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // reset in the middle of a dcache tenure
        cycle(0, 1, 32'h0, 32'h0000_4000, 0, 0, 0);
        cycle(0, 1, 32'h0, 32'h0000_4000, 0, 0, 1);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_l2_valid", 32'(l2_if.req_valid), 32'd0);
        chk("midreset_owner", 32'(arb_owner), 32'(ARB_IDLE));
        chk("midreset_overrun", 32'(beat_overrun), 32'd0);
        dc_if.req_valid = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        icv = 1'b0;
        dcv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) icv = ~icv;
            if ($urandom_range(4) == 0) dcv = ~dcv;
            cycle(icv, dcv, {$urandom_range(32'hFFFF), 2'b00}, {$urandom_range(32'hFFFF), 2'b00},
                  $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1);
        end
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        #5;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
Shares the single L2 request port between the instruction cache (ic) and data cache (dc). Each L1 presents the same request/fulfil handshake it would drive straight into L2. The arbiter grants one L1 at a time and holds the grant across a multi-beat line fill or writeback until that L1 drops valid. It sits between both L1 controllers and L2/main memory.

Parameters:
XLEN, 32, address/data width in bits
LINE_SIZE, 16, bytes per cache line; used only for the beat-count sanity limit (LINE_SIZE/4 beats)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
ic_req_address  input  XLEN  icache request address
ic_req_type  input  memory_operation_e  LOAD/STORE
ic_req_valid  input  1  icache request valid
ic_word_to_store  input  XLEN  store data
ic_fetched_word  output  XLEN  returned word
ic_req_fulfilled  output  1  beat complete for icache
dc_req_address, dc_req_type, dc_req_valid, dc_word_to_store, dc_fetched_word, dc_req_fulfilled  same widths/directions as ic_*  dcache port
l2_req_address  output  XLEN  to L2
l2_req_type  output  memory_operation_e  to L2
l2_req_valid  output  1  to L2
l2_word_to_store  output  XLEN  to L2
l2_fetched_word  input  XLEN  from L2
l2_req_fulfilled  input  1  from L2, may be combinational on l2_req_*
arb_owner  output  arb_owner_e  current grant (IDLE/IC/DC)
beat_overrun  output  1  sticky; granted L1 exceeded LINE_SIZE/4 fulfilled beats in one tenure

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_grant=IC, beat count=0, beat_overrun=0. l2_req_valid=0, ic/dc_req_fulfilled=0, fetched words pass l2_fetched_word.
- States: IDLE, GRANT_IC, GRANT_DC. State is registered; all muxing is combinational from state, so no added latency once granted.
- IDLE: both valid -> winner per priority (below); one valid -> that one; none -> stay. Transition takes one clock, giving one cycle of arbitration latency from IDLE.
- GRANT_x: l2_req_* = x_req_*; x_req_fulfilled = l2_req_fulfilled; x_fetched_word = l2_fetched_word. Non-granted port: fulfilled=0. l2_req_valid = x_req_valid.
- Release: at an edge where x_req_valid=0 -> GRANT_other if other valid (no IDLE bubble), else IDLE. last_grant<=x.
- The grant is never preempted while x_req_valid=1, regardless of the other port.
- Beat counter: increments on l2_req_fulfilled in a grant and clears on release. If the counter is already LINE_SIZE/4 and another beat fulfils, set beat_overrun (sticky until reset). The counter saturates.
- Type/address changes while granted (e.g. writeback then refill) are passed through unchanged; this is the same tenure.
- Reset mid-tenure: drops l2_req_valid immediately (asynchronously); the L1 re-requests after reset.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests in IDLE (or at release), the port that was not last_grant wins.
- Undefined: fixed priority, dc always wins ties. last_grant is still kept but is unused for decisions.

Decomposition:
- xentry_pkg: add arb_owner_e {ARB_IDLE, ARB_IC, ARB_DC}; reuse memory_operation_e.
- No sub-module needed; the optional l1_l2_arb_pick function (priority decision) goes in the package.

Test Plan:
- Only dc_req_valid=1, LOAD 0x0000_1000, held 4 beats -> arb_owner=DC one cycle later; dc_fetched_word tracks memory per beat; ic_req_fulfilled stays 0; IDLE after valid drops.
- ic and dc both raise valid in the same cycle from reset -> fixed: DC granted first, IC granted the cycle DC drops valid with no IDLE cycle. With ARB_ROUND_ROBIN_EN: first DC (last_grant=IC at reset), next tie IC.
- ic granted mid-fill (beat 2 of 4), dc raises valid -> IC keeps grant through beat 4; dc_req_fulfilled=0 throughout.
- dc STORE writeback to 0x0000_2040 then LOAD refill 0x0000_3040 without dropping valid -> single tenure; l2_req_type follows STORE then LOAD.
- Granted L1 receives 5 fulfilled beats without dropping valid -> beat_overrun=1 after beat 5 and stays set.
- reset_n pulsed low while GRANT_DC -> l2_req_valid=0 within the same cycle; arb_owner=IDLE; beat_overrun=0.
